cpu_csr_axi_master: RTL and testbench

- Upstream master stage for cpu_csr (AXI4 slave, 5-bit address, 32-bit data).
- Converts the CPU core's single-word CSR request/response interface into single-beat AXI4 write and read transactions.
- One transaction outstanding at a time.
- Checks response codes and IDs, and returns read data or an error flag to the core.

---
 rtl/cpu_csr_axi_master.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu_csr_axi_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_csr_axi_master.sv
// cpu_csr_axi_master
//
// Turns the core's single-word CSR request/response handshake into single-beat
// AXI4 write (AW + W -> B) and read (AR -> R) transactions, one at a time.
// Each transaction is tagged with a rolling ID. The B/R response code, the ID
// and (for reads) rlast are checked, and the result goes back to the core on the
// rsp_* handshake.
//
// Ports
//   s_aclk, s_aresetn             clock, asynchronous active-low reset
//   req_valid/req_ready           core request handshake (req_ready only in idle)
//   req_write/addr/wdata/wstrb    request payload, latched on acceptance
//   rsp_valid/rsp_ready           core response handshake
//   rsp_rdata, rsp_err            read data (0 for writes) and error flag
//   m_axi_aw*/w*/b*               AXI4 write channels
//   m_axi_ar*/r*                  AXI4 read channels
//
// Every non-constant output is a flop. Handshake outputs are registered
// decodes of the next state, so they change exactly on state transitions.

module cpu_csr_axi_master #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 5
) (
    input  logic                    s_aclk,
    input  logic                    s_aresetn,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [1:0]              m_axi_awburst,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [1:0]              m_axi_arburst,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrB,
        StRdA,
        StRdR,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [ID_WIDTH-1:0]     tag_q, tag_d;
    logic [ID_WIDTH-1:0]     ctr_q, ctr_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic req_ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        tag_d     = tag_q;
        ctr_d     = ctr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    tag_d     = ctr_q;
                    ctr_d     = ctr_q + ID_WIDTH'(1);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write ? StWr : StRdA;
                end
            end
            StWr: begin
                // AW and W complete independently; both may finish on one edge.
                if (awvalid_q && m_axi_awready) aw_done_d = 1'b1;
                if (wvalid_q && m_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)      state_d   = StWrB;
            end
            StWrB: begin
                if (m_axi_bvalid) begin
                    rdata_d = '0;
                    err_d   = (m_axi_bresp != 2'b00) || (m_axi_bid != tag_q);
                    state_d = StResp;
                end
            end
            StRdA: begin
                // arvalid_q is high for the whole stay in this state.
                if (m_axi_arready) state_d = StRdR;
            end
            StRdR: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    err_d   = (m_axi_rresp != 2'b00) || (m_axi_rid != tag_q) || !m_axi_rlast;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            tag_q       <= '0;
            ctr_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            tag_q       <= tag_d;
            ctr_q       <= ctr_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= (state_d == StIdle);
            awvalid_q   <= (state_d == StWr) && !aw_done_d;
            wvalid_q    <= (state_d == StWr) && !w_done_d;
            bready_q    <= (state_d == StWrB);
            arvalid_q   <= (state_d == StRdA);
            rready_q    <= (state_d == StRdR);
            rsp_valid_q <= (state_d == StResp);
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awid    = tag_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'b010;

    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = wvalid_q;

    assign m_axi_bready  = bready_q;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arid    = tag_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b010;

    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_cpu_csr_axi_master.sv
// Bench for cpu_csr_axi_master: a behavioural AXI slave with fault injection,
// a reference memory plus an expected-response queue, a per-cycle compare
// process, and directed transactions with hand-computed literal expectations.

module tb_cpu_csr_axi_master;

    logic        s_aclk = 1'b0;
    logic        s_aresetn = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  awaddr, awid, araddr, arid;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
    logic [1:0]  awburst, arburst;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0, bready;
    logic        arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [4:0]  rid = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;

    always #5 s_aclk = ~s_aclk;

    cpu_csr_axi_master dut (
        .s_aclk        (s_aclk),
        .s_aresetn     (s_aresetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .m_axi_awaddr  (awaddr),
        .m_axi_awid    (awid),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_awburst (awburst),
        .m_axi_awlen   (awlen),
        .m_axi_awsize  (awsize),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wlast   (wlast),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bid     (bid),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arid    (arid),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_arburst (arburst),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_rdata   (rdata),
        .m_axi_rid     (rid),
        .m_axi_rresp   (rresp),
        .m_axi_rlast   (rlast),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [4:0]  id;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [32];
    logic [31:0] mem [32];
    logic [4:0]  ref_id = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Slave knobs and observations
    int          aw_wait = 0;
    logic [1:0]  inj_bresp = '0;
    logic [4:0]  inj_rid_xor = '0;
    logic        inj_rlast0 = 1'b0;
    logic        r_stall = 1'b0;
    int          b_count = 0;
    int          aw_cycles = 0, w_cycles = 0, rsp_cycles = 0;
    logic [4:0]  last_awaddr = '0, last_awid = '0, last_arid = '0;
    logic [31:0] last_wdata = '0;
    logic        last_wlast = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Behavioural AXI slave. Acts at the negedge: sets ready/valid for the next
    // posedge and treats valid && ready as the handshake at that edge.
    logic       got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0, b_taken = 1'b0, r_taken = 1'b0;
    logic [4:0] s_awaddr = '0, s_awid = '0, s_araddr = '0, s_arid = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;

    initial begin : slave
        forever begin
            @(negedge s_aclk);
            if (!s_aresetn) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                got_aw = 0; got_w = 0; got_ar = 0; b_taken = 0; r_taken = 0;
            end else begin
                if (b_taken) begin bvalid = 0; b_taken = 0; end
                if (!bvalid && got_aw && got_w) begin
                    if (inj_bresp == 2'b00) mem[s_awaddr] = merge(mem[s_awaddr], s_wdata, s_wstrb);
                    bvalid = 1; bid = s_awid; bresp = inj_bresp;
                    got_aw = 0; got_w = 0;
                end
                b_taken = bvalid && bready;
                if (b_taken) b_count++;

                if (r_taken) begin rvalid = 0; r_taken = 0; end
                if (!rvalid && got_ar && !r_stall) begin
                    rvalid = 1; rdata = mem[s_araddr]; rid = s_arid ^ inj_rid_xor;
                    rresp = 2'b00; rlast = !inj_rlast0; got_ar = 0;
                end
                r_taken = rvalid && rready;

                if (awvalid && !got_aw) begin
                    if (aw_wait > 0) begin awready = 0; aw_wait--; end
                    else awready = 1;
                end else awready = 0;
                if (awvalid && awready) begin got_aw = 1; s_awaddr = awaddr; s_awid = awid; end

                wready = wvalid && !got_w;
                if (wvalid && wready) begin got_w = 1; s_wdata = wdata; s_wstrb = wstrb; end

                arready = arvalid && !got_ar;
                if (arvalid && arready) begin got_ar = 1; s_araddr = araddr; s_arid = arid; end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the expected-transaction queue.
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge s_aclk);
            if (s_aresetn) begin
                if (exp_q.size() != 0) e = exp_q[0];
                if (awvalid || wvalid || arvalid || bready || rready || rsp_valid)
                    check("req_ready_busy", 32'(req_ready), 32'd0);
                if (awvalid) begin
                    aw_cycles++;
                    last_awaddr = awaddr; last_awid = awid;
                    check("aw_pending", 32'(exp_q.size() != 0 && e.wr), 32'd1);
                    check("awaddr", 32'(awaddr), 32'(e.addr));
                    check("awid", 32'(awid), 32'(e.id));
                    check("aw_const", {21'd0, awburst, awlen, awsize}, {21'd0, 2'b01, 8'd0, 3'b010});
                end
                if (wvalid) begin
                    w_cycles++;
                    last_wdata = wdata; last_wlast = wlast;
                    check("w_pending", 32'(exp_q.size() != 0 && e.wr), 32'd1);
                    check("wdata", wdata, e.wdata);
                    check("wstrb", 32'(wstrb), 32'(e.wstrb));
                    check("wlast", 32'(wlast), 32'd1);
                end
                if (arvalid) begin
                    last_arid = arid;
                    check("ar_pending", 32'(exp_q.size() != 0 && !e.wr), 32'd1);
                    check("araddr", 32'(araddr), 32'(e.addr));
                    check("arid", 32'(arid), 32'(e.id));
                    check("ar_const", {21'd0, arburst, arlen, arsize}, {21'd0, 2'b01, 8'd0, 3'b010});
                end
                if (rsp_valid) begin
                    rsp_cycles++;
                    check("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Present a request and return #1 after the edge that accepted it.
    task automatic issue(input logic wr, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        exp_t e;
        int n;
        @(posedge s_aclk); #1;
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        n = 0;
        @(negedge s_aclk);
        while (!req_ready && n < 50) begin @(negedge s_aclk); n++; end
        check("req_accept", 32'(req_ready), 32'd1);
        if (!req_ready) begin req_valid = 0; return; end
        e.wr = wr; e.addr = a; e.id = ref_id; e.wdata = d; e.wstrb = s;
        e.rdata = wr ? 32'd0 : ref_mem[a];
        e.err = wr ? (inj_bresp != 2'b00) : (inj_rid_xor != 5'd0 || inj_rlast0);
        if (wr && inj_bresp == 2'b00) ref_mem[a] = merge(ref_mem[a], d, s);
        exp_q.push_back(e);
        ref_id = ref_id + 5'd1;
        @(posedge s_aclk); #1;
        // Scramble the request; the DUT must ignore it after acceptance.
        req_valid = 0; req_write = ~wr; req_addr = ~a; req_wdata = ~d; req_wstrb = ~s;
    endtask

    task automatic wait_rsp(input int hold, output int lat, output logic [31:0] rd,
                            output logic err);
        int n;
        lat = 0; n = 0; rd = '0; err = 1'b0;
        @(negedge s_aclk);
        while (!rsp_valid && n < 100) begin
            @(posedge s_aclk); lat++;
            @(negedge s_aclk); n++;
        end
        check("rsp_arrives", 32'(rsp_valid), 32'd1);
        if (!rsp_valid) return;
        rd = rsp_rdata; err = rsp_err;
        repeat (hold) @(posedge s_aclk);
        #1 rsp_ready = 1;
        @(posedge s_aclk); #1;
    endtask

    task automatic xact(input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, output int lat,
                        output logic [31:0] rd, output logic err);
        if (hold > 0) rsp_ready = 0;
        issue(wr, a, d, s);
        wait_rsp(hold, lat, rd, err);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat, bc;
        logic [31:0] rd;
        logic        err;
        for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end

        #3;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        check("rst_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
        repeat (2) @(posedge s_aclk);
        #2 s_aresetn = 1;
        @(posedge s_aclk); @(negedge s_aclk);
        check("req_ready_after_rst", 32'(req_ready), 32'd1);

        // First write and read-back
        xact(1, 5'd3, 32'hA5A5A5A8, 4'hF, 0, lat, rd, err);
        check("w1_awaddr", 32'(last_awaddr), 32'd3);
        check("w1_awid", 32'(last_awid), 32'd0);
        check("w1_wdata", last_wdata, 32'hA5A5A5A8);
        check("w1_wlast", 32'(last_wlast), 32'd1);
        check("w1_err", 32'(err), 32'd0);
        check("w1_rdata", rd, 32'd0);
        check("w1_latency", lat, 2);
        xact(0, 5'd3, 32'd0, 4'h0, 0, lat, rd, err);
        check("r1_arid", 32'(last_arid), 32'd1);
        check("r1_rdata", rd, 32'hA5A5A5A8);
        check("r1_err", 32'(err), 32'd0);
        check("r1_latency", lat, 2);

        for (int a = 0; a < 5; a++) xact(1, 5'(a), 32'hA5A5A5A5 + a, 4'hF, 0, lat, rd, err);
        for (int a = 0; a < 5; a++) begin
            xact(0, 5'(a), 32'd0, 4'h0, 0, lat, rd, err);
            check("r5_rdata", rd, 32'hA5A5A5A5 + a);
        end

        // Delayed awready, partial strobe
        aw_wait = 4; aw_cycles = 0; w_cycles = 0; bc = b_count;
        xact(1, 5'd7, 32'h12345678, 4'h5, 0, lat, rd, err);
        check("dly_aw_cycles", aw_cycles, 5);
        check("dly_w_cycles", w_cycles, 1);
        check("dly_b_count", b_count - bc, 1);
        check("dly_err", 32'(err), 32'd0);
        xact(0, 5'd7, 32'd0, 4'h0, 0, lat, rd, err);
        check("strb_rdata", rd, 32'h00340078);

        // Error responses
        inj_bresp = 2'b10;
        xact(1, 5'd8, 32'h00000001, 4'hF, 0, lat, rd, err);
        check("bresp_err", 32'(err), 32'd1);
        inj_bresp = 2'b00;
        xact(0, 5'd8, 32'd0, 4'h0, 0, lat, rd, err);
        check("bresp_not_written", rd, 32'd0);
        inj_rid_xor = 5'd1;
        xact(0, 5'd3, 32'd0, 4'h0, 0, lat, rd, err);
        check("rid_err", 32'(err), 32'd1);
        check("rid_err_rdata", rd, 32'hA5A5A5A8);
        inj_rid_xor = 5'd0;
        inj_rlast0 = 1;
        xact(0, 5'd4, 32'd0, 4'h0, 0, lat, rd, err);
        check("rlast_err", 32'(err), 32'd1);
        inj_rlast0 = 0;

        // Response back-pressure
        rsp_cycles = 0;
        xact(0, 5'd1, 32'd0, 4'h0, 5, lat, rd, err);
        check("bp_rdata", rd, 32'hA5A5A5A6);
        check("bp_rsp_cycles", rsp_cycles, 6);

        // Reset while waiting in the read-data phase
        r_stall = 1;
        issue(0, 5'd2, 32'd0, 4'h0);
        repeat (2) @(posedge s_aclk);
        @(negedge s_aclk);
        check("rd_r_rready", 32'(rready), 32'd1);
        @(posedge s_aclk);
        #2 s_aresetn = 0;
        #1;
        check("arst_valids", {29'd0, arvalid, rready, rsp_valid}, 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        ref_id = '0;
        repeat (2) @(negedge s_aclk);
        @(posedge s_aclk);
        #2 s_aresetn = 1; r_stall = 0;
        @(posedge s_aclk); @(negedge s_aclk);
        check("req_ready_after_arst", 32'(req_ready), 32'd1);
        xact(0, 5'd0, 32'd0, 4'h0, 0, lat, rd, err);
        check("arst_next_arid", 32'(last_arid), 32'd0);
        check("arst_rdata", rd, 32'hA5A5A5A5);

        // ID wrap: 31 more reads take IDs 1..31, the next one wraps to 0
        for (int i = 1; i < 33; i++) begin
            xact(0, 5'(i % 5), 32'd0, 4'h0, 0, lat, rd, err);
            check("wrap_arid", 32'(last_arid), 32'(i % 32));
        end

        repeat (3) @(posedge s_aclk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
